// File: rtl/cdb_arbiter_if.sv
// Result-producer / common-data-bus signal bundle for cdb_arbiter.
// master = producers and CDB consumers, slave = the arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned DATA_W    = 32
);
    logic                 alu_valid;
    logic [ROB_IDX_W-1:0] alu_src;
    logic [DATA_W-1:0]    alu_val;
    logic                 alu_tk;
    logic                 alu_ready;

    logic                 ld_valid;
    logic [ROB_IDX_W-1:0] ld_src;
    logic [DATA_W-1:0]    ld_val;
    logic                 ld_ready;

    logic                 cdb_valid;
    logic [ROB_IDX_W-1:0] cdb_src;
    logic [DATA_W-1:0]    cdb_val;
    logic                 cdb_tk;
    logic                 cdb_from_ld;

    modport master (
        output alu_valid, alu_src, alu_val, alu_tk,
        output ld_valid, ld_src, ld_val,
        input  alu_ready, ld_ready,
        input  cdb_valid, cdb_src, cdb_val, cdb_tk, cdb_from_ld
    );

    modport slave (
        input  alu_valid, alu_src, alu_val, alu_tk,
        input  ld_valid, ld_src, ld_val,
        output alu_ready, ld_ready,
        output cdb_valid, cdb_src, cdb_val, cdb_tk, cdb_from_ld
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Merges ALU and load results through two 2-entry FIFOs onto one registered CDB.
// Define CDB_ARB_RR_EN for round-robin grant; otherwise load wins when both are pending.
module cdb_arbiter #(
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned DATA_W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         rb,
    cdb_arbiter_if.slave bus
);
    typedef struct packed {
        logic [ROB_IDX_W-1:0] src;
        logic [DATA_W-1:0]    val;
        logic                 tk;
    } entry_t;

    entry_t     alu_mem [2];
    entry_t     ld_mem  [2];
    logic       alu_head, alu_tail, ld_head, ld_tail;
    logic [1:0] alu_cnt, ld_cnt;

    logic       adv_c, alu_ne_c, ld_ne_c, grant_ld_c;
    logic       alu_push_c, ld_push_c, alu_pop_c, ld_pop_c;
    entry_t     alu_in_c, ld_in_c;

    logic                 cdb_valid_q;
    logic [ROB_IDX_W-1:0] cdb_src_q;
    logic [DATA_W-1:0]    cdb_val_q;
    logic                 cdb_tk_q;
    logic                 cdb_from_ld_q;

    assign adv_c    = rdy && !rb;
    assign alu_ne_c = (alu_cnt != 2'd0);
    assign ld_ne_c  = (ld_cnt != 2'd0);

    assign bus.alu_ready = (alu_cnt != 2'd2) && !rb;
    assign bus.ld_ready  = (ld_cnt != 2'd2) && !rb;

    assign alu_in_c = {bus.alu_src, bus.alu_val, bus.alu_tk};
    assign ld_in_c  = {bus.ld_src, bus.ld_val, 1'b0};

    assign alu_push_c = adv_c && bus.alu_valid && bus.alu_ready;
    assign ld_push_c  = adv_c && bus.ld_valid && bus.ld_ready;

`ifdef CDB_ARB_RR_EN
    // Last-grant flag: 1 = load was granted most recently.
    logic last_ld;

    always_comb begin
        grant_ld_c = ld_ne_c;
        if (alu_ne_c && ld_ne_c) begin
            grant_ld_c = !last_ld;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ld <= 1'b1;
        end else if (adv_c && (alu_ne_c || ld_ne_c)) begin
            last_ld <= grant_ld_c;
        end
    end
`else
    assign grant_ld_c = ld_ne_c;
`endif

    assign ld_pop_c  = adv_c && grant_ld_c;
    assign alu_pop_c = adv_c && alu_ne_c && !grant_ld_c;

    function automatic logic [1:0] next_cnt(input logic [1:0] cnt, input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return cnt + 2'd1;
            2'b01:   return cnt - 2'd1;
            default: return cnt;
        endcase
    endfunction

    // FIFO bookkeeping; rollback empties both queues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_head <= 1'b0;
            alu_tail <= 1'b0;
            alu_cnt  <= 2'd0;
            ld_head  <= 1'b0;
            ld_tail  <= 1'b0;
            ld_cnt   <= 2'd0;
        end else if (rdy) begin
            if (rb) begin
                alu_head <= 1'b0;
                alu_tail <= 1'b0;
                alu_cnt  <= 2'd0;
                ld_head  <= 1'b0;
                ld_tail  <= 1'b0;
                ld_cnt   <= 2'd0;
            end else begin
                if (alu_push_c) alu_tail <= ~alu_tail;
                if (alu_pop_c)  alu_head <= ~alu_head;
                if (ld_push_c)  ld_tail  <= ~ld_tail;
                if (ld_pop_c)   ld_head  <= ~ld_head;
                alu_cnt <= next_cnt(alu_cnt, alu_push_c, alu_pop_c);
                ld_cnt  <= next_cnt(ld_cnt, ld_push_c, ld_pop_c);
            end
        end
    end

    // Payload storage is qualified by the counts, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alu_push_c) alu_mem[alu_tail] <= alu_in_c;
        if (ld_push_c)  ld_mem[ld_tail]   <= ld_in_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid_q   <= 1'b0;
            cdb_src_q     <= '0;
            cdb_val_q     <= '0;
            cdb_tk_q      <= 1'b0;
            cdb_from_ld_q <= 1'b0;
        end else if (rdy) begin
            if (alu_pop_c) begin
                cdb_valid_q   <= 1'b1;
                cdb_src_q     <= alu_mem[alu_head].src;
                cdb_val_q     <= alu_mem[alu_head].val;
                cdb_tk_q      <= alu_mem[alu_head].tk;
                cdb_from_ld_q <= 1'b0;
            end else if (ld_pop_c) begin
                cdb_valid_q   <= 1'b1;
                cdb_src_q     <= ld_mem[ld_head].src;
                cdb_val_q     <= ld_mem[ld_head].val;
                cdb_tk_q      <= ld_mem[ld_head].tk;
                cdb_from_ld_q <= 1'b1;
            end else begin
                cdb_valid_q   <= 1'b0;
            end
        end
    end

    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_src     = cdb_src_q;
    assign bus.cdb_val     = cdb_val_q;
    assign bus.cdb_tk      = cdb_tk_q;
    assign bus.cdb_from_ld = cdb_from_ld_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus queues expected broadcasts,
// a negedge monitor pops and compares them. Expectations follow CDB_ARB_RR_EN.
module tb_cdb_arbiter;
    typedef struct packed {
        logic [3:0]  src;
        logic [31:0] val;
        logic        tk;
        logic        from_ld;
    } bc_t;

`ifdef CDB_ARB_RR_EN
    localparam logic       EXP_ALU_STALL = 1'b0;
    localparam logic       EXP_LD_STALL  = 1'b1;
    localparam logic [3:0] FRZ_SRC       = 4'd4;
    localparam logic [31:0] FRZ_VAL      = 32'h104;
    localparam logic       FRZ_FROM_LD   = 1'b0;
    localparam logic       FRZ_ALU_RDY   = 1'b1;
    localparam logic       FRZ_LD_RDY    = 1'b0;
    localparam logic [3:0] S6_SRC        = 4'd6;
`else
    localparam logic       EXP_ALU_STALL = 1'b1;
    localparam logic       EXP_LD_STALL  = 1'b0;
    localparam logic [3:0] FRZ_SRC       = 4'd12;
    localparam logic [31:0] FRZ_VAL      = 32'h20C;
    localparam logic       FRZ_FROM_LD   = 1'b1;
    localparam logic       FRZ_ALU_RDY   = 1'b0;
    localparam logic       FRZ_LD_RDY    = 1'b1;
    localparam logic [3:0] S6_SRC        = 4'd14;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic rb  = 1'b0;
    logic rdy_q = 1'b0;

    int total = 0;
    int bad   = 0;
    bc_t exp_q[$];

    cdb_arbiter_if #(.ROB_IDX_W(4), .DATA_W(32)) bus ();

    cdb_arbiter #(.ROB_IDX_W(4), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .rb  (rb),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bc_t alu_bc(input logic [3:0] s);
        return {s, 32'h100 + 32'(s), s[0], 1'b0};
    endfunction

    function automatic bc_t ld_bc(input logic [3:0] s);
        return {s, 32'h200 + 32'(s), 1'b0, 1'b1};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a broadcast is new only if the preceding edge had rdy=1.
    always @(posedge clk) rdy_q = rdy;

    always @(negedge clk) begin
        bc_t got, e;
        if (!rst && rdy_q && bus.cdb_valid) begin
            got = {bus.cdb_src, bus.cdb_val, bus.cdb_tk, bus.cdb_from_ld};
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL broadcast: got src=%0d val=%0h from_ld=%0b expected none",
                         got.src, got.val, got.from_ld);
            end else begin
                e = exp_q.pop_front();
                check("broadcast", 64'(got), 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [3:0] s);
        bus.alu_valid = v;
        bus.alu_src   = s;
        bus.alu_val   = 32'h100 + 32'(s);
        bus.alu_tk    = s[0];
    endtask

    task automatic set_ld(input logic v, input logic [3:0] s);
        bus.ld_valid = v;
        bus.ld_src   = s;
        bus.ld_val   = 32'h200 + 32'(s);
    endtask

    task automatic do_reset();
        set_alu(1'b0, 4'd0);
        set_ld(1'b0, 4'd0);
        rdy = 1'b1;
        rb  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s drain: %0d broadcasts outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Producer holds its offer until it sees ready before an edge.
    task automatic alu_offer(input logic [3:0] s, output logic stalled);
        logic acc;
        int n;
        set_alu(1'b1, s);
        acc = 1'b0;
        stalled = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = bus.alu_ready;
            if (!acc) stalled = 1'b1;
            tick();
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL alu_offer src=%0d: accepted=0 expected 1", s);
        end
        bus.alu_valid = 1'b0;
    endtask

    task automatic ld_offer(input logic [3:0] s, output logic stalled);
        logic acc;
        int n;
        set_ld(1'b1, s);
        acc = 1'b0;
        stalled = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = bus.ld_ready;
            if (!acc) stalled = 1'b1;
            tick();
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL ld_offer src=%0d: accepted=0 expected 1", s);
        end
        bus.ld_valid = 1'b0;
    endtask

    initial begin
        logic alu_st, ld_st;
        set_alu(1'b0, 4'd0);
        set_ld(1'b0, 4'd0);
        tick();
        tick();
        check("reset cdb_valid during rst", 64'(bus.cdb_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("reset cdb_valid", 64'(bus.cdb_valid), 64'd0);
        check("reset cdb_src", 64'(bus.cdb_src), 64'd0);
        check("reset cdb_val", 64'(bus.cdb_val), 64'd0);
        check("reset cdb_tk", 64'(bus.cdb_tk), 64'd0);
        check("reset cdb_from_ld", 64'(bus.cdb_from_ld), 64'd0);
        check("reset alu_ready", 64'(bus.alu_ready), 64'd1);
        check("reset ld_ready", 64'(bus.ld_ready), 64'd1);

        // Single ALU result: two-edge latency, one-cycle valid.
        do_reset();
        set_alu(1'b1, 4'd3);
        bus.alu_val = 32'h0000_00AA;
        bus.alu_tk  = 1'b1;
        exp_q.push_back({4'd3, 32'hAA, 1'b1, 1'b0});
        tick();
        set_alu(1'b0, 4'd0);
        check("s1 no bypass", 64'(bus.cdb_valid), 64'd0);
        tick();
        check("s1 valid", 64'(bus.cdb_valid), 64'd1);
        check("s1 src", 64'(bus.cdb_src), 64'd3);
        check("s1 val", 64'(bus.cdb_val), 64'hAA);
        check("s1 tk", 64'(bus.cdb_tk), 64'd1);
        check("s1 from_ld", 64'(bus.cdb_from_ld), 64'd0);
        tick();
        check("s1 valid drops", 64'(bus.cdb_valid), 64'd0);
        drain("s1");

        // Simultaneous ALU src1 / load src2.
        do_reset();
`ifdef CDB_ARB_RR_EN
        exp_q.push_back(alu_bc(4'd1));
        exp_q.push_back(ld_bc(4'd2));
`else
        exp_q.push_back(ld_bc(4'd2));
        exp_q.push_back(alu_bc(4'd1));
`endif
        set_alu(1'b1, 4'd1);
        set_ld(1'b1, 4'd2);
        tick();
        set_alu(1'b0, 4'd0);
        set_ld(1'b0, 4'd0);
        drain("s2");

        // ALU 4,5,6 competing with load 8,9,10; backpressure and producer hold.
        do_reset();
`ifdef CDB_ARB_RR_EN
        exp_q.push_back(alu_bc(4'd4));
        exp_q.push_back(ld_bc(4'd8));
        exp_q.push_back(alu_bc(4'd5));
        exp_q.push_back(ld_bc(4'd9));
        exp_q.push_back(alu_bc(4'd6));
        exp_q.push_back(ld_bc(4'd10));
`else
        exp_q.push_back(ld_bc(4'd8));
        exp_q.push_back(ld_bc(4'd9));
        exp_q.push_back(ld_bc(4'd10));
        exp_q.push_back(alu_bc(4'd4));
        exp_q.push_back(alu_bc(4'd5));
        exp_q.push_back(alu_bc(4'd6));
`endif
        alu_st = 1'b0;
        ld_st  = 1'b0;
        fork
            begin
                logic st;
                for (int i = 0; i < 3; i++) begin
                    alu_offer(4'(4 + i), st);
                    alu_st = alu_st | st;
                end
            end
            begin
                logic st;
                for (int i = 0; i < 3; i++) begin
                    ld_offer(4'(8 + i), st);
                    ld_st = ld_st | st;
                end
            end
        join
        drain("s3");
        check("s3 alu stalled", 64'(alu_st), 64'(EXP_ALU_STALL));
        check("s3 ld stalled", 64'(ld_st), 64'(EXP_LD_STALL));

        // Rollback with entries buffered.
        do_reset();
`ifdef CDB_ARB_RR_EN
        exp_q.push_back(alu_bc(4'd2));
`else
        exp_q.push_back(ld_bc(4'd3));
`endif
        set_alu(1'b1, 4'd2);
        set_ld(1'b1, 4'd3);
        tick();
        set_alu(1'b1, 4'd7);
        set_ld(1'b1, 4'd9);
        tick();
        rb = 1'b1;
        #1;
        check("s4 alu_ready in rb", 64'(bus.alu_ready), 64'd0);
        check("s4 ld_ready in rb", 64'(bus.ld_ready), 64'd0);
        tick();
        rb = 1'b0;
        set_alu(1'b0, 4'd0);
        set_ld(1'b0, 4'd0);
        #1;
        check("s4 valid after rb", 64'(bus.cdb_valid), 64'd0);
        check("s4 alu_ready after rb", 64'(bus.alu_ready), 64'd1);
        check("s4 ld_ready after rb", 64'(bus.ld_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s4 quiet", 64'(bus.cdb_valid), 64'd0);
        end
        drain("s4");

        // rdy low for 5 edges with both queues occupied.
        do_reset();
`ifdef CDB_ARB_RR_EN
        exp_q.push_back(alu_bc(4'd4));
        exp_q.push_back(ld_bc(4'd12));
        exp_q.push_back(alu_bc(4'd5));
        exp_q.push_back(ld_bc(4'd13));
`else
        exp_q.push_back(ld_bc(4'd12));
        exp_q.push_back(ld_bc(4'd13));
        exp_q.push_back(alu_bc(4'd4));
        exp_q.push_back(alu_bc(4'd5));
`endif
        set_alu(1'b1, 4'd4);
        set_ld(1'b1, 4'd12);
        tick();
        set_alu(1'b1, 4'd5);
        set_ld(1'b1, 4'd13);
        tick();
        set_alu(1'b0, 4'd0);
        set_ld(1'b0, 4'd0);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s5 frozen valid", 64'(bus.cdb_valid), 64'd1);
            check("s5 frozen src", 64'(bus.cdb_src), 64'(FRZ_SRC));
            check("s5 frozen val", 64'(bus.cdb_val), 64'(FRZ_VAL));
            check("s5 frozen from_ld", 64'(bus.cdb_from_ld), 64'(FRZ_FROM_LD));
            check("s5 frozen alu_ready", 64'(bus.alu_ready), 64'(FRZ_ALU_RDY));
            check("s5 frozen ld_ready", 64'(bus.ld_ready), 64'(FRZ_LD_RDY));
        end
        rdy = 1'b1;
        drain("s5");

        // Asynchronous reset between edges with two entries pending.
        do_reset();
        set_alu(1'b1, 4'd6);
        set_ld(1'b1, 4'd14);
        tick();
        set_alu(1'b1, 4'd7);
        set_ld(1'b0, 4'd0);
        tick();
        set_alu(1'b0, 4'd0);
        check("s6 valid before rst", 64'(bus.cdb_valid), 64'd1);
        check("s6 src before rst", 64'(bus.cdb_src), 64'(S6_SRC));
        #2;
        rst = 1'b1;
        #1;
        check("s6 valid in rst", 64'(bus.cdb_valid), 64'd0);
        check("s6 src in rst", 64'(bus.cdb_src), 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s6 no stale", 64'(bus.cdb_valid), 64'd0);
        end
        check("s6 alu_ready", 64'(bus.alu_ready), 64'd1);
        check("s6 ld_ready", 64'(bus.ld_ready), 64'd1);
        check("final queue empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter ROB_IDX_W, default 4, ROB index width.
REQ-002 Parameter DATA_W, default 32, result data width.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rdy  input  1  global ready; low freezes all state and outputs.
REQ-006 rb  input  1  rollback; flushes all buffered results.
REQ-007 alu_valid  input  1  ALU result offered this cycle.
REQ-008 alu_src  input  ROB_IDX_W  ROB index of ALU result.
REQ-009 alu_val  input  DATA_W  ALU result value.
REQ-010 alu_tk  input  1  branch-taken flag from ALU.
REQ-011 alu_ready  output  1  ALU FIFO can accept this cycle.
REQ-012 ld_valid  input  1  load result offered this cycle.
REQ-013 ld_src  input  ROB_IDX_W  ROB index of load result.
REQ-014 ld_val  input  DATA_W  load result value.
REQ-015 ld_ready  output  1  load FIFO can accept this cycle.
REQ-016 cdb_valid  output  1  broadcast valid, registered.
REQ-017 cdb_src  output  ROB_IDX_W  broadcast ROB index, registered.
REQ-018 cdb_val  output  DATA_W  broadcast value, registered.
REQ-019 cdb_tk  output  1  taken flag; 0 for load results, registered.
REQ-020 cdb_from_ld  output  1  1 = broadcast originates from load, registered.

Function
REQ-021 Each source SHALL own a 2-entry FIFO (head pointer, tail pointer, 2-bit count 0..2).
REQ-022 alu_ready/ld_ready SHALL be combinational: count != 2, forced 0 while rb is high.
REQ-023 Push SHALL occur on an edge where rdy=1, rb=0, valid=1, ready=1; valid with ready=0 SHALL be dropped (producer holds).
REQ-024 Each rdy=1, rb=0 edge SHALL pop at most one entry total, chosen per REQ-025/Configuration, and register it onto cdb_*; with no nonempty FIFO, cdb_valid SHALL go 0.
REQ-025 Grant SHALL go only to a nonempty FIFO; with exactly one nonempty FIFO, it SHALL be granted.
REQ-026 Latency: result pushed into an empty FIFO at edge N, when granted, SHALL appear on cdb_* for the cycle after edge N+1; no same-cycle bypass.
REQ-027 Same-edge push and pop on one FIFO SHALL be legal at any count below 2; count unchanged.
REQ-028 Pointers SHALL wrap modulo 2; count SHALL never exceed 2 or underflow.
REQ-029 cdb_valid SHALL be high exactly one cycle per granted entry; each accepted result broadcast exactly once unless flushed.
REQ-030 rb=1 at an edge (rdy=1): both counts to 0, pointers to 0, cdb_valid to 0, inputs that cycle ignored.
REQ-031 rdy=0: no push, no pop, no pointer change; cdb_* hold previous values.

Reset
REQ-032 rst SHALL asynchronously clear counts, pointers, round-robin pointer and all cdb_* outputs to 0, mid-operation included; buffered data discarded.
REQ-033 After rst deasserts, alu_ready and ld_ready SHALL read 1.

Configuration
REQ-034 Macro CDB_ARB_RR_EN defined: both FIFOs nonempty -> grant the source not granted last; 1-bit last-grant register updates on every grant, reset value "load granted last".
REQ-035 CDB_ARB_RR_EN undefined: both nonempty -> load always wins (fixed priority); no last-grant register.

Verification
REQ-036 After reset, alu_valid=1, src=3, val=0x0000_00AA, tk=1 at edge 1 -> cdb_valid=1, src=3, val=0xAA, tk=1, from_ld=0 after edge 2, cdb_valid=0 after edge 3.
REQ-037 ALU and load push simultaneously (src 1 / src 2) with RR enabled -> ALU src 1 broadcast first, load src 2 next cycle; RR disabled -> load src 2 first.
REQ-038 Three consecutive alu_valid pushes, no load, pop blocked by prior stream -> alu_ready=0 when count=2, third value held by producer and accepted later; broadcast order src 4,5,6.
REQ-039 Fill both FIFOs (4 entries), assert rb one cycle -> cdb_valid=0 next cycle and no further broadcasts; alu_ready=ld_ready=1.
REQ-040 rdy=0 for 5 cycles while both FIFOs hold entries -> cdb_* frozen, counts unchanged; broadcasting resumes in original order after rdy=1.
REQ-041 rst asserted between edges with 2 entries pending -> cdb_valid=0 immediately, no stale entry broadcast after release.
